// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern and length.
// The next prefix length is recomputed each cycle by a direct border search, so any len works without re-synthesis.
module seq_detect_param #(
    parameter int                 LEN_MAX     = 8,
    parameter int                 DEF_LEN     = 5,
    parameter logic [LEN_MAX-1:0] DEF_PATTERN = 8'b0001_0110,
    parameter int                 OVERLAP     = 1,
    parameter int                 CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       inp,
    input  logic                       cfg_load,
    input  logic [LEN_MAX-1:0]         cfg_pattern,
    input  logic [4:0]                 cfg_len,
    output logic                       outp,
    output logic [CNT_W-1:0]           match_cnt,
    output logic [$clog2(LEN_MAX)-1:0] state,
    output logic                       cfg_err
);

    localparam int          SW   = $clog2(LEN_MAX);
    localparam int unsigned LM   = LEN_MAX;
    localparam logic [4:0]  LEN5 = 5'(LEN_MAX);

    logic [LEN_MAX-1:0] pat;
    logic [4:0]         len;
    logic               legal;
    logic               hit;
    logic [SW-1:0]      next_state;

    // Bit k of the pattern in arrival order.
    function automatic logic pbit(input logic [LEN_MAX-1:0] p, input int unsigned l,
                                  input int unsigned k);
        logic [LEN_MAX-1:0] sh;
        sh = p >> (l - 1 - k);
        return sh[0];
    endfunction

    assign legal = (cfg_len >= 5'd2) && (cfg_len <= LEN5);
    assign hit   = (5'(state) == len - 5'd1) && (inp == pat[0]);
    assign outp  = rst && en && !cfg_load && hit;

    // Longest pattern prefix (shorter than len) that ends the string
    // "matched prefix, then inp". On a completed match this is the full-pattern border.
    always_comb begin
        int unsigned st;
        int unsigned ln;
        int unsigned best;
        int unsigned pos;
        logic        ok;
        logic        b;
        st   = 32'(state);
        ln   = 32'(len);
        best = 0;
        pos  = 0;
        ok   = 1'b0;
        b    = 1'b0;
        for (int unsigned j = 1; j < LM; j++) begin
            if ((j <= st + 1) && (j < ln)) begin
                ok = 1'b1;
                for (int unsigned t = 0; t < LM - 1; t++) begin
                    if (t < j) begin
                        pos = st + 1 - j + t;
                        b   = (pos == st) ? inp : pbit(pat, ln, pos);
                        if (pbit(pat, ln, t) != b) ok = 1'b0;
                    end
                end
                if (ok) best = j;
            end
        end
        if (hit && (OVERLAP == 0)) next_state = '0;
        else                       next_state = SW'(best);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat       <= DEF_PATTERN;
            len       <= 5'(DEF_LEN);
            state     <= '0;
            match_cnt <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_load && !legal;
            if (cfg_load && legal) begin
                pat       <= cfg_pattern;
                len       <= cfg_len;
                state     <= '0;
                match_cnt <= '0;
            end else if (en) begin
                state <= next_state;
                if (hit && (match_cnt != '1)) match_cnt <= match_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter) checked against a history-based model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, en, inp, cfg_load;
    logic [7:0] cfg_pattern;
    logic [4:0] cfg_len;

    logic       o0, o1, o2, e0, e1, e2;
    logic [7:0] c0, c1;
    logic [1:0] c2;
    logic [2:0] s0, s1, s2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.OVERLAP(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .outp(o0), .match_cnt(c0), .state(s0), .cfg_err(e0));

    seq_detect_param #(.OVERLAP(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .outp(o1), .match_cnt(c1), .state(s1), .cfg_err(e1));

    seq_detect_param #(.OVERLAP(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .inp(inp), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .outp(o2), .match_cnt(c2), .state(s2), .cfg_err(e2));

    // Reference: text accepted since reset/load (or since last match without overlap).
    logic [7:0]  m_pat [3];
    int unsigned m_len [3];
    int unsigned m_cnt [3];
    bit          m_err [3];
    bit          hist  [3][$];
    int unsigned m_max [3] = '{255, 255, 3};
    bit          m_ovl [3] = '{1'b1, 1'b0, 1'b1};

    bit          exp_out [3];
    int unsigned exp_st  [3];
    int unsigned exp_cnt [3];
    bit          exp_err [3];
    bit          act_out [3];
    int unsigned act_st  [3];
    int unsigned act_cnt [3];
    bit          act_err [3];

    function automatic bit pbit(int i, int unsigned k);
        logic [7:0] v;
        v = m_pat[i] >> (m_len[i] - 1 - k);
        return v[0];
    endfunction

    function automatic bit ends_with_prefix(bit h[$], int i, int unsigned k);
        if (h.size() < k) return 1'b0;
        for (int unsigned t = 0; t < k; t++)
            if (h[h.size() - k + t] != pbit(i, t)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int unsigned model_state(int i);
        for (int k = int'(m_len[i]) - 1; k > 0; k--)
            if (ends_with_prefix(hist[i], i, k)) return k;
        return 0;
    endfunction

    function automatic bit completes(int i, bit d);
        bit t[$];
        t = hist[i];
        t.push_back(d);
        return ends_with_prefix(t, i, m_len[i]);
    endfunction

    function automatic void model_reset(int i);
        m_pat[i] = 8'b0001_0110;
        m_len[i] = 5;
        m_cnt[i] = 0;
        m_err[i] = 1'b0;
        hist[i].delete();
    endfunction

    function automatic void model_update(int i, bit r, bit e, bit d, bit l,
                                         logic [7:0] p, int unsigned ln);
        bit ok;
        if (!r) begin
            model_reset(i);
            return;
        end
        ok = (ln >= 2) && (ln <= 8);
        m_err[i] = l && !ok;
        if (l && ok) begin
            m_pat[i] = p;
            m_len[i] = ln;
            m_cnt[i] = 0;
            hist[i].delete();
        end else if (e) begin
            if (completes(i, d)) begin
                if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                hist[i].push_back(d);
                if (!m_ovl[i]) hist[i].delete();
            end else begin
                hist[i].push_back(d);
            end
            while (hist[i].size() > 16) void'(hist[i].pop_front());
        end
    endfunction

    // Applies one cycle of inputs, records expected/actual pre-edge values, then advances the model.
    task automatic drive(input bit r, input bit e, input bit d, input bit l,
                         input logic [7:0] p, input logic [4:0] ln);
        @(posedge clk);
        #1;
        rst = r; en = e; inp = d; cfg_load = l; cfg_pattern = p; cfg_len = ln;
        for (int i = 0; i < 3; i++) begin
            exp_out[i] = r && e && !l && completes(i, d);
            exp_st[i]  = model_state(i);
            exp_cnt[i] = m_cnt[i];
            exp_err[i] = m_err[i];
        end
        @(negedge clk);
        act_out = '{o0, o1, o2};
        act_st  = '{32'(s0), 32'(s1), 32'(s2)};
        act_cnt = '{32'(c0), 32'(c1), 32'(c2)};
        act_err = '{e0, e1, e2};
        for (int i = 0; i < 3; i++) model_update(i, r, e, d, l, p, 32'(ln));
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 5'd2);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (act_st[i] !== 0 || act_cnt[i] !== 0 || act_err[i] !== 1'b0 || act_out[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset dut%0d: state=%0d cnt=%0d err=%0b outp=%0b, want all 0",
                         i, act_st[i], act_cnt[i], act_err[i], act_out[i]);
            end
        end
    endtask

    task automatic test_stream();
        bit s[17] = '{0,1,1,0,1,1,0,1,0,1,0,1,0,1,1,0,0};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 1'b1, s[k], 1'b0, 8'h00, 5'd0);
            total++;
            if (o0 !== ((k == 6) || (k == 15))) begin
                bad++;
                $display("FAIL stream bit%0d: outp=%0b want %0b", k, o0, (k == 6) || (k == 15));
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        total++;
        if (c0 !== 8'd2) begin
            bad++;
            $display("FAIL stream count: cnt=%0d want 2", c0);
        end
    endtask

    task automatic test_overlap();
        bit s[8] = '{1,0,1,1,0,1,1,0};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, s[k], 1'b0, 8'h00, 5'd0);
            total++;
            if (o0 !== ((k == 4) || (k == 7)) || o1 !== (k == 4)) begin
                bad++;
                $display("FAIL overlap bit%0d: ovl=%0b nonovl=%0b want %0b %0b",
                         k, o0, o1, (k == 4) || (k == 7), k == 4);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        total++;
        if (c0 !== 8'd2 || c1 !== 8'd1) begin
            bad++;
            $display("FAIL overlap count: ovl=%0d nonovl=%0d want 2 1", c0, c1);
        end
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_0111, 5'd3);
        total++;
        if (o0 !== 1'b0) begin
            bad++;
            $display("FAIL load cycle outp=%0b want 0", o0);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0);
            if (k == 0) begin
                total++;
                if (s0 !== 3'd0 || c0 !== 8'd0) begin
                    bad++;
                    $display("FAIL load clear: state=%0d cnt=%0d want 0 0", s0, c0);
                end
            end
            total++;
            if (o0 !== (k >= 2) || o1 !== exp_out[1]) begin
                bad++;
                $display("FAIL load stream bit%0d: outp=%0b/%0b want %0b/%0b",
                         k, o0, o1, k >= 2, exp_out[1]);
            end
        end
    endtask

    task automatic test_bad_len();
        bit s[5] = '{1,0,1,1,0};
        bit err_seen[6];
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 5'd1);
        err_seen[0] = e0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        err_seen[1] = e0;
        total++;
        if (s0 !== 3'd1) begin
            bad++;
            $display("FAIL bad_len bit processed: state=%0d want 1", s0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 5'd9);
        err_seen[2] = e0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        err_seen[3] = e0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        err_seen[4] = e0;
        total++;
        if (err_seen[0] !== 1'b0 || err_seen[1] !== 1'b1 || err_seen[2] !== 1'b0 ||
            err_seen[3] !== 1'b1 || err_seen[4] !== 1'b0) begin
            bad++;
            $display("FAIL bad_len err pulses=%0b%0b%0b%0b%0b want 01010",
                     err_seen[0], err_seen[1], err_seen[2], err_seen[3], err_seen[4]);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, s[k], 1'b0, 8'h00, 5'd0);
            total++;
            if (o0 !== (k == 4)) begin
                bad++;
                $display("FAIL bad_len match bit%0d: outp=%0b want %0b", k, o0, k == 4);
            end
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_0011, 5'd2);
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0);
            drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 5'd0);
            total++;
            if (32'(c2) !== ((k < 3) ? k : 3) || o2 !== 1'b0) begin
                bad++;
                $display("FAIL saturate bit%0d: cnt=%0d outp=%0b want %0d 0",
                         k, c2, o2, (k < 3) ? k : 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit s[4] = '{1,0,1,1};
        bit f[5] = '{1,0,1,1,0};
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, s[k], 1'b0, 8'h00, 5'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
        total++;
        if (o0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid during rst: outp=%0b want 0", o0);
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0);
        total++;
        if (o0 !== 1'b0 || s0 !== 3'd0) begin
            bad++;
            $display("FAIL reset_mid restart: outp=%0b state=%0d want 0 0", o0, s0);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, f[k], 1'b0, 8'h00, 5'd0);
            total++;
            if (o0 !== (k == 4)) begin
                bad++;
                $display("FAIL reset_mid fresh bit%0d: outp=%0b want %0b", k, o0, k == 4);
            end
        end
    endtask

    task automatic test_random();
        bit r, e, d, l;
        logic [7:0] p;
        logic [4:0] ln;
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 99) != 0);
            l  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = 1'($urandom_range(0, 1));
            p  = 8'($urandom);
            ln = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 10)) : 5'($urandom_range(2, 5));
            if (l && (ln < 2 || ln > 8)) e = 1'b0;
            drive(r, e, d, l, p, ln);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (act_out[i] !== exp_out[i] || act_st[i] !== exp_st[i] ||
                    act_cnt[i] !== exp_cnt[i] || act_err[i] !== exp_err[i]) begin
                    bad++;
                    $display("FAIL random n=%0d dut%0d: outp=%0b st=%0d cnt=%0d err=%0b want %0b %0d %0d %0b",
                             n, i, act_out[i], act_st[i], act_cnt[i], act_err[i],
                             exp_out[i], exp_st[i], exp_cnt[i], exp_err[i]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; inp = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0;
        for (int i = 0; i < 3; i++) model_reset(i);
        test_reset();
        test_stream();
        test_overlap();
        test_load();
        test_bad_len();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
